// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the fan control path: FSM state encodings and default widths.
package fan_ctrl_pkg;

    localparam int unsigned COUNTER_BITWIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_KICK  = 2'd1,
        ST_RAMP  = 2'd2,
        ST_TRACK = 2'd3
    } fan_state_e;

endpackage

// File: rtl/clk_en_prescaler.sv
// Clock-enable divider: registered one-cycle strobe every prescaler+1 clocks.
// The divide ratio is reloaded only on wrap so a change never produces a short interval.
module clk_en_prescaler #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] prescaler_i,
    output logic             clk_en_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] prescaler_q, prescaler_d;
    logic             clk_en_q, clk_en_d;

    always_comb begin
        cnt_d       = cnt_q + WIDTH'(1);
        prescaler_d = prescaler_q;
        clk_en_d    = 1'b0;
        if (cnt_q == prescaler_q) begin
            cnt_d       = '0;
            prescaler_d = prescaler_i;
            clk_en_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q       <= '0;
            prescaler_q <= '0;
            clk_en_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            prescaler_q <= prescaler_d;
            clk_en_q    <= clk_en_d;
        end
    end

    assign clk_en_o = clk_en_q;

endmodule

// File: rtl/fan_duty_sequencer.sv
// Fan PWM control stage: start-up kick at maximum duty, then a slew-limited ramp
// toward the requested duty, with all duty updates aligned to PWM period ends.
module fan_duty_sequencer
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned COUNTER_BITWIDTH   = COUNTER_BITWIDTH_DEFAULT,
    parameter int unsigned PRESCALER_BITWIDTH = 8,
    parameter int unsigned KICK_PERIODS       = 8,
    parameter int unsigned RAMP_STEP_PERIODS  = 2
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          enable_i,
    input  logic [PRESCALER_BITWIDTH-1:0] prescaler_i,
    input  logic [COUNTER_BITWIDTH-1:0]   targetValue_i,
    input  logic [COUNTER_BITWIDTH-1:0]   minCounterValue_i,
    input  logic [COUNTER_BITWIDTH:0]     periodCounterValue_i,
    output logic                          clk_en_o,
    output logic [COUNTER_BITWIDTH-1:0]   counterValue_o,
    output logic [COUNTER_BITWIDTH-1:0]   minCounterValue_o,
    output logic [COUNTER_BITWIDTH:0]     periodCounterValue_o,
    output logic [1:0]                    state_o
);

    localparam int unsigned CW       = COUNTER_BITWIDTH;
    localparam int unsigned PW       = COUNTER_BITWIDTH + 1;
    localparam int unsigned KW       = $clog2(KICK_PERIODS + 1);
    localparam int unsigned SW       = $clog2(RAMP_STEP_PERIODS + 1);
    localparam int unsigned DUTY_MAX = (2 ** COUNTER_BITWIDTH) - 1;

    logic clk_en;

    clk_en_prescaler #(
        .WIDTH(PRESCALER_BITWIDTH)
    ) u_prescaler (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .prescaler_i(prescaler_i),
        .clk_en_o   (clk_en)
    );

    logic [PW-1:0] per_val_q, per_val_d;
    logic [PW-1:0] per_cnt_q, per_cnt_d;
    logic [PW-1:0] per_q, per_d;
    logic          period_end;

    // Period tracker mirrors the PWM generator's own counter and reload behaviour.
    always_comb begin
        per_val_d  = periodCounterValue_i;
        per_cnt_d  = per_cnt_q;
        per_d      = per_q;
        period_end = clk_en && (per_cnt_q == per_q);
        if (period_end) begin
            per_cnt_d = '0;
            per_d     = per_val_q;
        end else if (clk_en) begin
            per_cnt_d = per_cnt_q + PW'(1);
        end
    end

    logic [PW-1:0] min_ext;
    logic [PW-1:0] headroom;
    logic [CW-1:0] limit;
    logic [CW-1:0] eff_target;

    // Duty ceiling: period minus floor, saturated to the duty width, never wrapping.
    always_comb begin
        min_ext  = {1'b0, minCounterValue_i};
        headroom = per_val_q - min_ext;
        limit    = '0;
        if (per_val_q > min_ext) begin
            limit = (headroom > PW'(DUTY_MAX)) ? CW'(DUTY_MAX) : headroom[CW-1:0];
        end
        eff_target = (targetValue_i < limit) ? targetValue_i : limit;
    end

    fan_state_e    state_q, state_d;
    logic [CW-1:0] duty_q, duty_d;
    logic [CW-1:0] floor_q, floor_d;
    logic [KW-1:0] kick_cnt_q, kick_cnt_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic          run_req;
    logic          kick_done;
    logic          step_due;

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        floor_d    = floor_q;
        kick_cnt_d = kick_cnt_q;
        step_cnt_d = step_cnt_q;
        run_req    = enable_i && (targetValue_i != '0);
        kick_done  = (kick_cnt_q == KW'(KICK_PERIODS - 1));
        step_due   = (step_cnt_q == SW'(RAMP_STEP_PERIODS - 1));

        if (!run_req) begin
            // Forced off wins over everything, including a coincident period end.
            state_d    = ST_OFF;
            duty_d     = '0;
            floor_d    = '0;
            kick_cnt_d = '0;
            step_cnt_d = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d    = ST_KICK;
                    kick_cnt_d = '0;
                end
                ST_KICK: begin
                    if (period_end) begin
                        duty_d  = limit;
                        floor_d = minCounterValue_i;
                        if (kick_done) begin
                            state_d    = ST_RAMP;
                            step_cnt_d = '0;
                        end else begin
                            kick_cnt_d = kick_cnt_q + KW'(1);
                        end
                    end
                end
                ST_RAMP: begin
                    if (period_end) begin
                        floor_d    = minCounterValue_i;
                        step_cnt_d = step_due ? '0 : step_cnt_q + SW'(1);
                        if (duty_q > limit) begin
                            duty_d = limit;
                            if (limit == eff_target) begin
                                state_d = ST_TRACK;
                            end
                        end else if (duty_q == eff_target) begin
                            state_d = ST_TRACK;
                        end else if (step_due) begin
                            duty_d = (duty_q < eff_target) ? duty_q + CW'(1) : duty_q - CW'(1);
                            if (duty_d == eff_target) begin
                                state_d = ST_TRACK;
                            end
                        end
                    end else if (duty_q == eff_target) begin
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (period_end) begin
                        floor_d = minCounterValue_i;
                    end
                    if (duty_q != eff_target) begin
                        state_d    = ST_RAMP;
                        step_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    duty_d  = '0;
                    floor_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            per_val_q  <= '0;
            per_cnt_q  <= '0;
            per_q      <= '0;
            state_q    <= ST_OFF;
            duty_q     <= '0;
            floor_q    <= '0;
            kick_cnt_q <= '0;
            step_cnt_q <= '0;
        end else begin
            per_val_q  <= per_val_d;
            per_cnt_q  <= per_cnt_d;
            per_q      <= per_d;
            state_q    <= state_d;
            duty_q     <= duty_d;
            floor_q    <= floor_d;
            kick_cnt_q <= kick_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign clk_en_o             = clk_en;
    assign counterValue_o       = duty_q;
    assign minCounterValue_o    = floor_q;
    assign periodCounterValue_o = per_val_q;
    assign state_o              = state_q;

endmodule
